// File: rtl/dct_transpose_buf_if.sv
// rtl/dct_transpose_buf_if.sv - row-in / vector-out handshake bundle for the transpose buffer
interface dct_transpose_buf_if #(
    parameter int DATA_W = 13,
    parameter int N      = 8
);
    localparam int IDX_W = $clog2(N);

    logic                  in_valid;
    logic                  in_ready;
    logic [N*DATA_W-1:0]   in_row;
    logic                  out_valid;
    logic                  out_ready;
    logic [N*DATA_W-1:0]   out_vec;
    logic [IDX_W-1:0]      out_idx;
    logic                  out_first;
    logic                  out_last;

    modport master (
        output in_valid, in_row, out_ready,
        input  in_ready, out_valid, out_vec, out_idx, out_first, out_last
    );

    modport slave (
        input  in_valid, in_row, out_ready,
        output in_ready, out_valid, out_vec, out_idx, out_first, out_last
    );
endinterface

// File: rtl/dct_transpose_buf.sv
// rtl/dct_transpose_buf.sv - ping-pong NxN transpose buffer between DCT row and column stages
module dct_transpose_buf #(
    parameter int DATA_W = 13,
    parameter int N      = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode_tr,
    dct_transpose_buf_if.slave  bus,
    output logic [15:0]         blk_cnt
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

    bank_st_e              bank_q [2];
    bank_st_e              bank_d [2];
    logic                  wb_q, wb_d, rb_q, rb_d;
    logic [IDX_W-1:0]      wr_row_q, wr_row_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [IDX_W-1:0]      out_idx_q, out_idx_d;
    logic                  mode_q, mode_d;
    logic                  rdy_en_q;
    logic                  out_valid_q, out_valid_d;
    logic [N*DATA_W-1:0]   out_vec_q, out_vec_d;
    logic [15:0]           blk_cnt_q, blk_cnt_d;
    logic [N*DATA_W-1:0]   mem_q [2][N];

    logic                  in_ready_w, wr_fire, out_load, drain_start, drain_busy, rd_mode;
    logic [IDX_W-1:0]      rd_sel;
    logic [N*DATA_W-1:0]   rd_vec;

    // rdy_en_q keeps in_ready low for the first cycle out of reset
    assign in_ready_w  = rdy_en_q && (bank_q[wb_q] == EMPTY || bank_q[wb_q] == FILLING);
    assign wr_fire     = bus.in_valid && in_ready_w;
    assign out_load    = !out_valid_q || bus.out_ready;
    assign drain_start = out_load && (bank_q[rb_q] == FULL);
    assign drain_busy  = out_load && (bank_q[rb_q] == DRAINING);
    assign rd_sel      = drain_start ? '0 : rd_idx_q;
    assign rd_mode     = drain_start ? mode_tr : mode_q;

    always_comb begin
        rd_vec = '0;
        if (rd_mode) begin
            for (int i = 0; i < N; i++)
                rd_vec[i*DATA_W +: DATA_W] = mem_q[rb_q][i][int'(rd_sel)*DATA_W +: DATA_W];
        end else begin
            rd_vec = mem_q[rb_q][rd_sel];
        end
    end

    always_comb begin
        bank_d      = bank_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        wr_row_d    = wr_row_q;
        rd_idx_d    = rd_idx_q;
        out_idx_d   = out_idx_q;
        mode_d      = mode_q;
        out_valid_d = out_valid_q;
        out_vec_d   = out_vec_q;
        blk_cnt_d   = blk_cnt_q;

        if (wr_fire) begin
            if (wr_row_q == IDX_W'(N-1)) begin
                bank_d[wb_q] = FULL;
                wb_d         = !wb_q;
                wr_row_d     = '0;
            end else begin
                bank_d[wb_q] = FILLING;
                wr_row_d     = wr_row_q + 1'b1;
            end
        end

        // The reader never touches bank[wb_q], so both updates can land in one cycle
        if (out_load) begin
            out_valid_d = drain_start || drain_busy;
            if (drain_start || drain_busy) begin
                out_vec_d = rd_vec;
                out_idx_d = rd_sel;
                if (drain_start) begin
                    mode_d       = mode_tr;
                    bank_d[rb_q] = DRAINING;
                end
                if (rd_sel == IDX_W'(N-1)) begin
                    bank_d[rb_q] = EMPTY;
                    rb_d         = !rb_q;
                    rd_idx_d     = '0;
                end else begin
                    rd_idx_d = rd_sel + 1'b1;
                end
            end
        end

        if (out_valid_q && bus.out_ready && out_idx_q == IDX_W'(N-1))
            blk_cnt_d = blk_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q[0]   <= EMPTY;
            bank_q[1]   <= EMPTY;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            wr_row_q    <= '0;
            rd_idx_q    <= '0;
            out_idx_q   <= '0;
            mode_q      <= 1'b0;
            rdy_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_vec_q   <= '0;
            blk_cnt_q   <= '0;
        end else begin
            bank_q      <= bank_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            wr_row_q    <= wr_row_d;
            rd_idx_q    <= rd_idx_d;
            out_idx_q   <= out_idx_d;
            mode_q      <= mode_d;
            rdy_en_q    <= 1'b1;
            out_valid_q <= out_valid_d;
            out_vec_q   <= out_vec_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem_q[wb_q][wr_row_q] <= bus.in_row;
    end

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_q;
    assign bus.out_vec   = out_vec_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_first = out_valid_q && (out_idx_q == '0);
    assign bus.out_last  = out_valid_q && (out_idx_q == IDX_W'(N-1));
    assign blk_cnt       = blk_cnt_q;
endmodule

// File: tb/tb_dct_transpose_buf.sv
// tb/tb_dct_transpose_buf.sv - directed and scoreboard bench for dct_transpose_buf
module tb_dct_transpose_buf;
    localparam int DATA_W = 13;
    localparam int N      = 8;
    typedef logic [N*DATA_W-1:0] vec_t;
    typedef struct { int k; int i; logic [DATA_W-1:0] exp; } probe_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mode_tr = 1'b1;
    logic [15:0] blk_cnt;

    dct_transpose_buf_if #(.DATA_W(DATA_W), .N(N)) bus ();
    dct_transpose_buf #(.DATA_W(DATA_W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .mode_tr(mode_tr), .bus(bus), .blk_cnt(blk_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;
    int   ready_drops = 0;
    bit   watch_ready = 0;
    vec_t exp_q[$];
    int   exp_idx_q[$];
    vec_t cap_q[$];
    vec_t rows_buf[N];
    vec_t mon_ev;
    int   mon_ei;
    probe_t probes[8];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #2;
        bus.out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_vector: got %h expected none", bus.out_vec);
            end else begin
                mon_ev = exp_q.pop_front();
                mon_ei = exp_idx_q.pop_front();
                check("out_vec", bus.out_vec, mon_ev);
                check("out_idx", bus.out_idx, mon_ei);
                check("out_first", bus.out_first, mon_ei == 0);
                check("out_last", bus.out_last, mon_ei == N-1);
                cap_q.push_back(bus.out_vec);
            end
        end
        if (watch_ready && !bus.in_ready) ready_drops++;
    end

    task automatic queue_block(input bit tr);
        vec_t v;
        for (int k = 0; k < N; k++) begin
            v = '0;
            for (int i = 0; i < N; i++)
                v[i*DATA_W +: DATA_W] = tr ? rows_buf[i][k*DATA_W +: DATA_W]
                                           : rows_buf[k][i*DATA_W +: DATA_W];
            exp_q.push_back(v);
            exp_idx_q.push_back(k);
        end
    endtask

    task automatic push_row(input vec_t r);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_row   = r;
        @(negedge clk);
        while (!bus.in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL push_row_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input bit tr);
        queue_block(tr);
        for (int k = 0; k < N; k++) push_row(rows_buf[k]);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 5000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        exp_idx_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                rows_buf[i][j*DATA_W +: DATA_W] = DATA_W'(16*i + j);
    endtask

    initial begin
        logic [DATA_W-1:0] pat[4];
        vec_t extra_row;

        probes[0] = '{0, 0, 13'd0};   probes[1] = '{0, 7, 13'd112};
        probes[2] = '{7, 0, 13'd7};   probes[3] = '{7, 7, 13'd119};
        probes[4] = '{3, 5, 13'd83};  probes[5] = '{5, 3, 13'd53};
        probes[6] = '{1, 2, 13'd33};  probes[7] = '{6, 4, 13'd70};
        pat[0] = 13'h1FFF; pat[1] = 13'h1000; pat[2] = 13'h0FFF; pat[3] = 13'h0001;

        bus.in_valid = 1'b0;
        bus.in_row   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_vec", bus.out_vec, 0);
        check("reset_out_idx", bus.out_idx, 0);
        check("reset_blk_cnt", blk_cnt, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_first_cycle", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("in_ready_after", bus.in_ready, 1);

        // single transposed ramp block with latency and probe table
        ready_mode = 1;
        mode_tr = 1'b1;
        fill_ramp();
        cap_q.delete();
        send_block(1'b1);
        bus.in_valid = 1'b0;
        check("latency_t1_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("latency_t2_valid", bus.out_valid, 1);
        check("latency_t2_idx", bus.out_idx, 0);
        wait_drain();
        check("blk_cnt_one", blk_cnt, 1);
        for (int p = 0; p < 8; p++) begin
            if (cap_q.size() > probes[p].k)
                check($sformatf("probe_k%0d_i%0d", probes[p].k, probes[p].i),
                      cap_q[probes[p].k][probes[p].i*DATA_W +: DATA_W], probes[p].exp);
            else
                check("probe_missing", 0, 1);
        end

        // three blocks back-to-back at full rate
        apply_reset();
        watch_ready = 1;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    rows_buf[i][j*DATA_W +: DATA_W] = DATA_W'(100*b + 10*i + j);
            send_block(1'b1);
        end
        bus.in_valid = 1'b0;
        watch_ready = 0;
        wait_drain();
        check("stream_in_ready_drops", ready_drops, 0);
        check("blk_cnt_three", blk_cnt, 3);

        // output stalled: two blocks fill, third row set is refused
        apply_reset();
        ready_mode = 0;
        fill_ramp();
        send_block(1'b1);
        for (int i = 0; i < N; i++) rows_buf[i] = ~rows_buf[i];
        send_block(1'b1);
        extra_row = '1;
        bus.in_row = extra_row;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_out_idx", bus.out_idx, 0);
            check("stall_out_vec", bus.out_vec, exp_q[0]);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ready_mode = 1;
        wait_drain();
        check("blk_cnt_stall", blk_cnt, 2);

        // bypass with sign-heavy data; mode flips mid-drain, next block transposes
        apply_reset();
        mode_tr = 1'b0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                rows_buf[i][j*DATA_W +: DATA_W] = pat[(i + j) % 4];
        send_block(1'b0);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        mode_tr = 1'b1;
        fill_ramp();
        send_block(1'b1);
        bus.in_valid = 1'b0;
        wait_drain();
        check("blk_cnt_bypass", blk_cnt, 2);

        // async reset mid-fill of block 1 while block 0 drains
        fill_ramp();
        send_block(1'b1);
        for (int k = 0; k < 5; k++) push_row(~rows_buf[k]);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_idx_q.delete();
        bus.in_valid = 1'b0;
        #1;
        check("async_rst_out_valid", bus.out_valid, 0);
        check("async_rst_blk_cnt", blk_cnt, 0);
        check("async_rst_in_ready", bus.in_ready, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        check("post_rst_in_ready_high", bus.in_ready, 1);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                rows_buf[i][j*DATA_W +: DATA_W] = DATA_W'(7*i + 3*j + 1);
        send_block(1'b1);
        bus.in_valid = 1'b0;
        wait_drain();
        check("blk_cnt_after_rst", blk_cnt, 1);

        // random back-pressure over 100 blocks
        apply_reset();
        ready_mode = 2;
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    rows_buf[i][j*DATA_W +: DATA_W] = DATA_W'($urandom);
            send_block(1'b1);
        end
        bus.in_valid = 1'b0;
        wait_drain();
        ready_mode = 1;
        check("blk_cnt_random", blk_cnt, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dct_transpose_buf.md
Name: dct_transpose_buf

Overview:
- Parametrised ping-pong transpose buffer between the row-transform and column-transform stages of the 2-D DCT pipeline.
- Replaces the single-bank transpose RAM and its free-running address counter.
- Accepts one N-element row per handshake, stores an NxN block, and emits it column by column.
- Two banks allow a new block to fill while the previous one drains; valid/ready handshakes on both sides.

Parameters:
- DATA_W, 13, bits per coefficient (two's complement, passed through unmodified); 4..32
- N, 8, block dimension (rows and columns per block); power of two, 4..16
- IDX_W, $clog2(N), width of row/column index outputs (derived, not overridden)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode_tr  in  1  1 = transpose (emit columns), 0 = bypass (emit rows in arrival order); sampled only when a bank starts draining
- in_valid  in  1  row data valid
- in_ready  out  1  buffer can accept a row this cycle
- in_row  in  N*DATA_W  row; element j at bits [j*DATA_W +: DATA_W]
- out_valid  out  1  out_vec valid
- out_ready  in  1  consumer accepts out_vec
- out_vec  out  N*DATA_W  column (or row in bypass); element i at bits [i*DATA_W +: DATA_W]
- out_idx  out  IDX_W  index of the vector currently on out_vec
- out_first  out  1  out_idx == 0 while out_valid
- out_last  out  1  out_idx == N-1 while out_valid
- blk_cnt  out  16  completed output blocks, wraps at 65535 -> 0

Behaviour:
- Storage: two banks (B0, B1), each NxN of DATA_W; no reset on contents.
- Bank state per bank: EMPTY, FILLING, FULL, DRAINING. Write pointer wb and read pointer rb, both initially B0.
- Reset (async, any time): both banks EMPTY, wb=rb=B0, row/column counters 0, in_ready=0 for the first cycle after deassertion then 1, out_valid=0, out_vec=0, out_idx=0, blk_cnt=0. A partial block in flight is discarded.
- Write side:
  - in_ready = bank[wb] is EMPTY or FILLING.
  - Row accepted when in_valid && in_ready; stored at row index wr_row, wr_row increments.
  - On acceptance of row N-1: bank[wb] -> FULL, wr_row -> 0, wb toggles.
  - in_row is ignored when in_valid=0.
- Read side:
  - When bank[rb] is FULL and the output register is empty or being consumed this cycle, bank[rb] -> DRAINING and mode_tr is latched for the whole block.
  - out_vec/out_idx/out_valid are registered; they change only on reset or when (!out_valid || out_ready).
  - Transpose: vector k element i = stored row i element k. Bypass: vector k = stored row k.
  - After vector N-1 is loaded into the output register: bank[rb] -> EMPTY, rb toggles; blk_cnt increments on the handshake of the out_last vector.
- Latency: row N-1 accepted at cycle t -> out_valid=1 with out_idx=0 at t+2 (bank state update, then output register load).
- Throughput: with out_ready held 1, sustained one row in / one vector out per cycle, with in_ready never deasserting.
- Simultaneous events:
  - A bank going EMPTY in the same cycle the writer needs it: the writer sees it free next cycle; no data loss.
  - Fill-complete and drain-start on the same bank in one cycle is impossible by construction; fill-complete on one bank and drain-complete on the other in the same cycle is legal.
- Stall: out_valid && !out_ready holds out_vec/out_idx stable. With both banks full, in_ready=0 until a drain completes.
- mode_tr changes mid-block take effect from the next block only.

Test Plan:
- N=8, DATA_W=13, mode_tr=1; row i element j = 16*i+j, one block, out_ready=1 -> 8 vectors, vector k element i = 16*i+k; out_first on k=0, out_last on k=7; first out_valid 2 cycles after row 7; blk_cnt=1.
- 3 blocks back-to-back, in_valid and out_ready held 1 -> in_ready never drops, 24 vectors contiguous, blk_cnt=3, data correct per block.
- out_ready=0 throughout, rows streamed -> 16 rows accepted, in_ready=0 from the 17th row onward; out_valid=1 with out_vec stable at vector 0 of block 0; release out_ready -> drains in order without loss.
- mode_tr=0 with elements 0x1FFF/0x1000 mix -> out_vec equals in_row per row, values unchanged (sign bits intact).
- Reset asserted after row 4 of block 1 while block 0 drains -> out_valid=0, blk_cnt=0 immediately; a new full block afterwards outputs correctly with no residue.
- Random out_ready (50%) over 100 blocks versus a scoreboard -> zero mismatches, blk_cnt=100.
